exception_ctrl_n: RTL and testbench
===================================

# exception_ctrl_n

Parametrised multi-source exception controller for the single-cycle LEGv8 datapath. It replaces the single-source exception block. It arbitrates NSRC prioritised exception requests and redirects fetch to a per-source vector. It keeps the return/link/status registers, serves MRS-style reads of them, and handles ERET. An optional one-level nesting stack is available.

## Interface
- N, 64, datapath width.
- NSRC, 4, number of exception sources; index 0 is highest priority; 1..16.
- EV_BASE, 'hD8, vector address of source 0.
- VEC_STRIDE, 'h80, spacing between per-source vectors.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- ExcReq  in  NSRC  level-sensitive request per source; held by the source until acked.
- EStatus  in  4*NSRC  4-bit cause code per source; source i uses bits [4i+3:4i].
- ERet  in  1  current instruction is ERET.
- NextPC_X  in  N  PC+4 of current instruction.
- imem_addr_X  in  N  PC of current instruction.
- ALUBranch_X  in  N  normal branch target from execute.
- EDataSel  in  2  register-read select (instruction bits [13:12]).
- ExcAck  out  NSRC  one-hot acknowledge, asserted in the acceptance cycle only.
- EProc_X  out  1  fetch must load EVAddr_X this cycle.
- EVAddr_X  out  N  vector of the accepted source.
- PCBranch_X  out  N  ERR when ERet, else ALUBranch_X.
- readData_X  out  N  selected exception register.
- InHandler  out  1  handler level > 0.

## Operation
- State: level counter L (0 = IDLE, 1 = HANDLER, 2 = NESTED, the last only with nesting).
- Live registers: ERR (return PC), ELR (faulting PC), ESR (4-bit cause), ESRC (source index).
- Arbitration: winner = lowest index i with ExcReq[i]=1, among eligible requests.
- Eligibility depends on L:
  - L=0: all requests are eligible.
  - L=1: eligible only with EXC_NEST_EN and only if i < ESRC.
  - L=2: nothing is eligible.
- Acceptance cycle (eligible winner exists, reset high):
  - Combinational: EProc_X=1, ExcAck[i]=1, EVAddr_X = EV_BASE + i*VEC_STRIDE (N-bit, wraps mod 2^N).
  - On the clock edge: ERR←NextPC_X, ELR←imem_addr_X, ESR←EStatus[i], ESRC←i, L←L+1.
  - Under nesting, the old live registers are copied to the shadow set in the same edge.
- When no eligible winner exists: EProc_X=0, ExcAck=0, EVAddr_X = EV_BASE.
- ERET, L>0, no acceptance this cycle:
  - PCBranch_X = ERR and L←L−1.
  - From L=2, the live registers are restored from the shadow set.
- ERET at L=0: PCBranch_X = ERR; no state change.
- Simultaneous acceptance and ERet:
  - Acceptance wins: EProc_X=1, L increments, ERet has no state effect.
  - Fetch gives EProc priority over PCSrc.
- Non-eligible requests stay pending without ack. They are re-arbitrated every cycle.
- readData_X by EDataSel:
  - 00 → ERR
  - 01 → ELR
  - 10 → zero-extended ESR
  - 11 → zero-extended ESRC

## Timing
- Arbitration, ExcAck, EProc_X, EVAddr_X, PCBranch_X and readData_X are combinational from the current inputs and state. There are zero cycles of latency to redirect.
- Register and level updates take one cycle. readData_X reflects the new exception in the cycle after acceptance.
- ExcAck is a single-cycle pulse. A source must drop ExcReq on the cycle after it sees its ack. A request still high is treated as a new exception.
- Reset (reset=0 at an edge), effective from any state including mid-handler:
  - L=0; ERR, ELR, ESR, ESRC and the shadows all clear to 0.
- While reset is low, outputs are forced regardless of inputs:
  - ExcAck=0, EProc_X=0, InHandler=0, EVAddr_X=EV_BASE.

## Configuration
- EXC_NEST_EN defined:
  - Shadow register set present; L ranges 0..2.
  - A strictly higher-priority request preempts a running handler.
  - ERET from L=2 restores the outer context.
- EXC_NEST_EN undefined:
  - No shadow set; L ranges 0..1.
  - All requests wait while L=1.

## Test plan
- Basic entry and return (reset, then ExcReq=4'b0100, EStatus[11:8]=4'h3, imem_addr_X='h40, NextPC_X='h44):
  - Same cycle: ExcAck=4'b0100, EProc_X=1, EVAddr_X='h1D8.
  - Next cycle: readData_X with EDataSel=00/01/10/11 gives 'h44/'h40/3/2.
  - ERet then: PCBranch_X='h44, InHandler falls.
- Priority: ExcReq=4'b1010 in IDLE → ExcAck=4'b0010, EVAddr_X='h158; source 3 stays pending and is accepted right after ERET.
- Nesting (EXC_NEST_EN), inside handler for source 2 with ERR='h44:
  - ExcReq[0] → ack, EVAddr_X='hD8.
  - ERet → PCBranch_X = NextPC at preemption.
  - Second ERet → PCBranch_X='h44.
- Without EXC_NEST_EN, same stimulus: no ack for source 0 until after the first ERet.
- Simultaneous ERet and ExcReq=4'b0001 in IDLE → EProc_X=1, ack source 0, L=1.
- Reset mid-handler: reset=0 for one edge at L=1 → InHandler=0, readData_X=0 for all EDataSel, and a pending request is accepted in the first cycle after reset is released.

Source files
------------

// File: rtl/exception_ctrl_n.sv
// Prioritised multi-source exception controller: arbitration, vectoring, ERR/ELR/ESR/ESRC, ERET; EXC_NEST_EN adds one nesting level.
// Latency: redirect and ack are combinational (0 cycles); registers and level update on the next rising edge.
// Backpressure: ineligible requests stay pending unacked and are re-arbitrated every cycle.
module exception_ctrl_n #(
    parameter int              N          = 64,
    parameter int              NSRC       = 4,
    parameter logic [N-1:0]    EV_BASE    = 'hD8,
    parameter logic [N-1:0]    VEC_STRIDE = 'h80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC-1:0]     ExcReq,
    input  logic [4*NSRC-1:0]   EStatus,
    input  logic                ERet,
    input  logic [N-1:0]        NextPC_X,
    input  logic [N-1:0]        imem_addr_X,
    input  logic [N-1:0]        ALUBranch_X,
    input  logic [1:0]          EDataSel,
    output logic [NSRC-1:0]     ExcAck,
    output logic                EProc_X,
    output logic [N-1:0]        EVAddr_X,
    output logic [N-1:0]        PCBranch_X,
    output logic [N-1:0]        readData_X,
    output logic                InHandler
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
`ifdef EXC_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    typedef enum logic [1:0] {
        L_IDLE    = 2'd0,
        L_HANDLER = 2'd1,
        L_NESTED  = 2'd2
    } level_e;

    level_e          level_q, level_d;
    logic [N-1:0]    err_q, err_d, elr_q, elr_d;
    logic [3:0]      esr_q, esr_d;
    logic [SW-1:0]   esrc_q, esrc_d;
`ifdef EXC_NEST_EN
    logic [N-1:0]    serr_q, serr_d, selr_q, selr_d;
    logic [3:0]      sesr_q, sesr_d;
    logic [SW-1:0]   sesrc_q, sesrc_d;
`endif

    logic [NSRC-1:0] elig;
    logic            found;
    logic [SW-1:0]   win;
    logic            accept;

    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NSRC; i++) begin
            case (level_q)
                L_IDLE:    elig[i] = ExcReq[i];
                // Only a strictly higher-priority source may preempt the running handler.
                L_HANDLER: elig[i] = ExcReq[i] && NEST && (i < int'(esrc_q));
                default:   elig[i] = 1'b0;
            endcase
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                win   = SW'(i);
            end
        end
    end

    assign accept     = found && reset;
    assign EProc_X    = accept;
    assign ExcAck     = accept ? (NSRC'(1) << win) : '0;
    assign EVAddr_X   = accept ? (EV_BASE + N'(win) * VEC_STRIDE) : EV_BASE;
    assign PCBranch_X = ERet ? err_q : ALUBranch_X;
    assign InHandler  = reset && (level_q != L_IDLE);

    always_comb begin
        case (EDataSel)
            2'b00:   readData_X = err_q;
            2'b01:   readData_X = elr_q;
            2'b10:   readData_X = N'(esr_q);
            default: readData_X = N'(esrc_q);
        endcase
    end

    always_comb begin
        level_d = level_q;
        err_d   = err_q;
        elr_d   = elr_q;
        esr_d   = esr_q;
        esrc_d  = esrc_q;
`ifdef EXC_NEST_EN
        serr_d  = serr_q;
        selr_d  = selr_q;
        sesr_d  = sesr_q;
        sesrc_d = sesrc_q;
`endif
        if (accept) begin
`ifdef EXC_NEST_EN
            serr_d  = err_q;
            selr_d  = elr_q;
            sesr_d  = esr_q;
            sesrc_d = esrc_q;
`endif
            err_d   = NextPC_X;
            elr_d   = imem_addr_X;
            esr_d   = EStatus[4*int'(win) +: 4];
            esrc_d  = win;
            level_d = (level_q == L_IDLE) ? L_HANDLER : L_NESTED;
        end else if (ERet && level_q != L_IDLE) begin
            level_d = (level_q == L_NESTED) ? L_HANDLER : L_IDLE;
`ifdef EXC_NEST_EN
            if (level_q == L_NESTED) begin
                err_d  = serr_q;
                elr_d  = selr_q;
                esr_d  = sesr_q;
                esrc_d = sesrc_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q <= L_IDLE;
            err_q   <= '0;
            elr_q   <= '0;
            esr_q   <= '0;
            esrc_q  <= '0;
`ifdef EXC_NEST_EN
            serr_q  <= '0;
            selr_q  <= '0;
            sesr_q  <= '0;
            sesrc_q <= '0;
`endif
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
            esrc_q  <= esrc_d;
`ifdef EXC_NEST_EN
            serr_q  <= serr_d;
            selr_q  <= selr_d;
            sesr_q  <= sesr_d;
            sesrc_q <= sesrc_d;
`endif
        end
    end
endmodule

// File: tb/tb_exception_ctrl_n.sv
// Directed bench for exception_ctrl_n: expectations queued as stimulus is driven, drained at the falling edge.
module tb_exception_ctrl_n;
    localparam int N    = 64;
    localparam int NSRC = 4;
    localparam int S_ACK = 0, S_EPROC = 1, S_EVA = 2, S_PCB = 3, S_RD = 4, S_INH = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   ExcReq;
    logic [4*NSRC-1:0] EStatus;
    logic              ERet;
    logic [N-1:0]      NextPC_X, imem_addr_X, ALUBranch_X;
    logic [1:0]        EDataSel;
    logic [NSRC-1:0]   ExcAck;
    logic              EProc_X;
    logic [N-1:0]      EVAddr_X, PCBranch_X, readData_X;
    logic              InHandler;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        int           sig;
        logic [N-1:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    exception_ctrl_n dut (
        .clk(clk), .reset(reset), .ExcReq(ExcReq), .EStatus(EStatus), .ERet(ERet),
        .NextPC_X(NextPC_X), .imem_addr_X(imem_addr_X), .ALUBranch_X(ALUBranch_X),
        .EDataSel(EDataSel), .ExcAck(ExcAck), .EProc_X(EProc_X), .EVAddr_X(EVAddr_X),
        .PCBranch_X(PCBranch_X), .readData_X(readData_X), .InHandler(InHandler)
    );

    task automatic expect_v(input string tag, input int sig, input logic [N-1:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [N-1:0] observe(input int sig);
        case (sig)
            S_ACK:   return N'(ExcAck);
            S_EPROC: return N'(EProc_X);
            S_EVA:   return EVAddr_X;
            S_PCB:   return PCBranch_X;
            S_RD:    return readData_X;
            default: return N'(InHandler);
        endcase
    endfunction

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t         e;
            logic [N-1:0] o;
            e = sb.pop_front();
            o = observe(e.sig);
            checks++;
            assert (o === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        drain();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic rd4(input string tag, input logic [N-1:0] e0, input logic [N-1:0] e1,
                       input logic [N-1:0] e2, input logic [N-1:0] e3);
        logic [N-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int s = 0; s < 4; s++) begin
            EDataSel = 2'(s);
            #1;
            expect_v($sformatf("%s_sel%0d", tag, s), S_RD, ev[s]);
            drain();
        end
        EDataSel = 2'b00;
    endtask

    initial begin
        reset = 1'b0; ExcReq = 4'b0001; EStatus = 16'h0350; ERet = 1'b0;
        NextPC_X = '0; imem_addr_X = '0; ALUBranch_X = 'h1234; EDataSel = 2'b00;
        #1;
        expect_v("rst_ack", S_ACK, 0);
        expect_v("rst_eproc", S_EPROC, 0);
        expect_v("rst_inh", S_INH, 0);
        expect_v("rst_evaddr", S_EVA, 'hD8);
        settle();
        rd4("rst_rd", 0, 0, 0, 0);
        adv();

        // basic entry for source 2
        reset = 1'b1; ExcReq = 4'b0100; imem_addr_X = 'h40; NextPC_X = 'h44;
        expect_v("entry_ack", S_ACK, 4'b0100);
        expect_v("entry_eproc", S_EPROC, 1);
        expect_v("entry_evaddr", S_EVA, 'h1D8);
        expect_v("entry_inh_before", S_INH, 0);
        expect_v("pcb_alu", S_PCB, 'h1234);
        settle(); adv();
        ExcReq = 4'b0000;
        expect_v("hdl_inh", S_INH, 1);
        expect_v("hdl_eproc", S_EPROC, 0);
        expect_v("hdl_evaddr_idle", S_EVA, 'hD8);
        settle();
        rd4("entry_rd", 'h44, 'h40, 3, 2);
        adv();
        ERet = 1'b1;
        expect_v("eret_pcb", S_PCB, 'h44);
        expect_v("eret_eproc", S_EPROC, 0);
        settle(); adv();
        ERet = 1'b0;
        expect_v("eret_inh", S_INH, 0);
        settle(); adv();

        // priority: sources 1 and 3
        ExcReq = 4'b1010; imem_addr_X = 'h100; NextPC_X = 'h104;
        expect_v("prio_ack", S_ACK, 4'b0010);
        expect_v("prio_evaddr", S_EVA, 'h158);
        settle(); adv();
        ExcReq = 4'b1000;
        expect_v("pend_ack", S_ACK, 0);
        expect_v("pend_eproc", S_EPROC, 0);
        expect_v("pend_inh", S_INH, 1);
        settle();
        rd4("prio_rd", 'h104, 'h100, 5, 1);
        adv();
        ERet = 1'b1;
        expect_v("pend_eret_ack", S_ACK, 0);
        expect_v("pend_eret_pcb", S_PCB, 'h104);
        settle(); adv();
        ERet = 1'b0;
        expect_v("pend_take_ack", S_ACK, 4'b1000);
        expect_v("pend_take_evaddr", S_EVA, 'h258);
        settle(); adv();
        ExcReq = 4'b0000; ERet = 1'b1;
        expect_v("src3_eret_pcb", S_PCB, 'h104);
        settle(); adv();

        // handler for source 2 with ERR='h44, then source 0 arrives
        ERet = 1'b0; ExcReq = 4'b0100; imem_addr_X = 'h40; NextPC_X = 'h44;
        expect_v("nest_outer_ack", S_ACK, 4'b0100);
        settle(); adv();
        ExcReq = 4'b0001; imem_addr_X = 'h200; NextPC_X = 'h204;
`ifdef EXC_NEST_EN
        expect_v("nest_ack", S_ACK, 4'b0001);
        expect_v("nest_evaddr", S_EVA, 'hD8);
        settle(); adv();
        ExcReq = 4'b0000; ERet = 1'b1;
        expect_v("nest_eret1_pcb", S_PCB, 'h204);
        settle(); adv();
        expect_v("nest_eret2_pcb", S_PCB, 'h44);
        expect_v("nest_eret2_inh", S_INH, 1);
        settle(); adv();
`else
        expect_v("nonest_ack", S_ACK, 0);
        expect_v("nonest_eproc", S_EPROC, 0);
        expect_v("nonest_evaddr", S_EVA, 'hD8);
        settle(); adv();
        ERet = 1'b1;
        expect_v("nonest_eret_ack", S_ACK, 0);
        expect_v("nonest_eret_pcb", S_PCB, 'h44);
        settle(); adv();
        ERet = 1'b0;
        expect_v("nonest_late_ack", S_ACK, 4'b0001);
        expect_v("nonest_late_evaddr", S_EVA, 'hD8);
        settle(); adv();
        ExcReq = 4'b0000; ERet = 1'b1;
        expect_v("nonest_late_pcb", S_PCB, 'h204);
        settle(); adv();
`endif
        ERet = 1'b0;
        expect_v("nest_done_inh", S_INH, 0);
        settle(); adv();

        // ERET together with a request in IDLE: acceptance wins
        ERet = 1'b1; ExcReq = 4'b0001; imem_addr_X = 'h300; NextPC_X = 'h304;
        expect_v("sim_eproc", S_EPROC, 1);
        expect_v("sim_ack", S_ACK, 4'b0001);
        settle(); adv();
        ERet = 1'b0; ExcReq = 4'b0000;
        expect_v("sim_inh", S_INH, 1);
        settle();
        rd4("sim_rd", 'h304, 'h300, 0, 0);
        adv();

        // reset while in a handler, with a request pending
        reset = 1'b0; ExcReq = 4'b0010;
        expect_v("mrst_ack", S_ACK, 0);
        expect_v("mrst_eproc", S_EPROC, 0);
        expect_v("mrst_inh", S_INH, 0);
        expect_v("mrst_evaddr", S_EVA, 'hD8);
        settle(); adv();
        expect_v("mrst_inh_after", S_INH, 0);
        settle();
        rd4("mrst_rd", 0, 0, 0, 0);
        adv();
        reset = 1'b1;
        expect_v("post_rst_ack", S_ACK, 4'b0010);
        expect_v("post_rst_eproc", S_EPROC, 1);
        expect_v("post_rst_evaddr", S_EVA, 'h158);
        settle(); adv();
        ExcReq = 4'b0000;
        expect_v("post_rst_inh", S_INH, 1);
        settle();
        rd4("post_rst_rd", 'h304, 'h300, 5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
